// File: rtl/te_pkg.sv
// Shared trace-encoder types: packet buffer, TCodes and N-Trace deframer enums.
package te_pkg;

  localparam int unsigned NTRACE_MAX_PACKET_WIDTH_IN_BYTES = 32;
  localparam int unsigned MDO_WIDTH = 6;

  typedef struct packed {
    logic [NTRACE_MAX_PACKET_WIDTH_IN_BYTES-1:0]   pkt_data_be;
    logic [5:0]                                    pkt_data_len;
    logic [NTRACE_MAX_PACKET_WIDTH_IN_BYTES*8-1:0] pkt_data;
  } pkt_buffer_t;

  typedef enum logic [5:0] {
    PKT_UNKNOWN                = 6'd0,
    PKT_OWNERSHIP              = 6'd2,
    PKT_DIRECTBRANCH           = 6'd3,
    PKT_INDIRECTBRANCH         = 6'd4,
    PKT_ERROR                  = 6'd8,
    PKT_PROGTRACESYNC          = 6'd9,
    PKT_DIRECTBRANCHSYNC       = 6'd11,
    PKT_INDIRECTBRANCHSYNC     = 6'd12,
    PKT_RESOURCEFULL           = 6'd27,
    PKT_INDIRECTBRANCHHIST     = 6'd28,
    PKT_INDIRECTBRANCHHISTSYNC = 6'd29,
    PKT_PROGTRACECORR          = 6'd33
  } Pkt_TCode_e;

  typedef enum logic [1:0] {
    MSEO_NORMAL = 2'b00,
    MSEO_EOF    = 2'b01,
    MSEO_RSVD   = 2'b10,
    MSEO_EOM    = 2'b11
  } Mseo_e;

  typedef enum logic [1:0] {
    DFERR_NONE      = 2'd0,
    DFERR_RSVD_MSEO = 2'd1,
    DFERR_OVERFLOW  = 2'd2
  } DeframeErr_e;

  typedef enum logic [1:0] {
    DF_IDLE,
    DF_COLLECT,
    DF_HOLD,
    DF_DROP
  } Deframer_State_e;

  // Raw 6-bit TCode to enum; codes this decoder does not know become PKT_UNKNOWN.
  function automatic Pkt_TCode_e to_tcode(input logic [5:0] t);
    Pkt_TCode_e r;
    r = PKT_UNKNOWN;
    case (t)
      6'd2:    r = PKT_OWNERSHIP;
      6'd3:    r = PKT_DIRECTBRANCH;
      6'd4:    r = PKT_INDIRECTBRANCH;
      6'd8:    r = PKT_ERROR;
      6'd9:    r = PKT_PROGTRACESYNC;
      6'd11:   r = PKT_DIRECTBRANCHSYNC;
      6'd12:   r = PKT_INDIRECTBRANCHSYNC;
      6'd27:   r = PKT_RESOURCEFULL;
      6'd28:   r = PKT_INDIRECTBRANCHHIST;
      6'd29:   r = PKT_INDIRECTBRANCHHISTSYNC;
      6'd33:   r = PKT_PROGTRACECORR;
      default: r = PKT_UNKNOWN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/te_mdo_packer.sv
// Packs 6-bit MDO chunks into the packet buffer and derives byte length/enables.
module te_mdo_packer
  import te_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        wr,
  input  logic [5:0]  idx,
  input  logic [5:0]  chunk,
  input  logic [5:0]  n_chunks,
  output pkt_buffer_t pkt
);

  localparam int unsigned DATA_W = NTRACE_MAX_PACKET_WIDTH_IN_BYTES * 8;

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] chunk_ext;
  logic [DATA_W-1:0] chunk_ins;
  logic [8:0]        bit_pos;
  logic [8:0]        bits_rnd;
  logic [5:0]        len;
  logic [NTRACE_MAX_PACKET_WIDTH_IN_BYTES-1:0] be;

  // Chunk placed at bit 6*idx.
  always_comb begin
    chunk_ext       = '0;
    chunk_ext[5:0]  = chunk;
    bit_pos         = 9'(idx) * 9'(MDO_WIDTH);
    chunk_ins       = chunk_ext << bit_pos;
  end

  // Start overwrites the whole buffer so stale upper bits never leak into a new message.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (start) begin
      data_q <= chunk_ext;
    end else if (wr) begin
      data_q <= data_q | chunk_ins;
    end
  end

  // len = ceil(6n/8), be = low len bits set.
  always_comb begin
    bits_rnd = 9'(n_chunks) * 9'(MDO_WIDTH) + 9'd7;
    len      = bits_rnd[8:3];
    be       = '0;
    for (int unsigned i = 0; i < NTRACE_MAX_PACKET_WIDTH_IN_BYTES; i++) begin
      be[i] = (i < 32'(len));
    end
  end

  assign pkt.pkt_data     = data_q;
  assign pkt.pkt_data_len = len;
  assign pkt.pkt_data_be  = be;

endmodule

// File: rtl/te_ntrace_deframer.sv
// Nexus MDO/MSEO byte-stream deframer: idle removal, message delimiting, TCode extraction.
module te_ntrace_deframer
  import te_pkg::*;
#(
  parameter int unsigned MAX_BYTES      = NTRACE_MAX_PACKET_WIDTH_IN_BYTES,
  parameter int unsigned MAX_CHUNKS     = (MAX_BYTES * 8) / 6,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_byte,
  output logic                      pkt_valid,
  input  logic                      pkt_ready,
  output pkt_buffer_t               pkt_out,
  output Pkt_TCode_e                pkt_tcode,
  output logic [5:0]                pkt_nfields,
  output logic                      err_valid,
  output logic [1:0]                err_code,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  Deframer_State_e state_q, state_d;
  Mseo_e           mseo;
  logic [5:0]      mdo;
  logic            accept;
  logic [5:0]      chunk_cnt;
  logic [5:0]      nfields_q;
  Pkt_TCode_e      tcode_q;
  logic            err_valid_q;
  DeframeErr_e     err_q;
  DeframeErr_e     err_d;
  logic            err_set;
  logic            start, wr, nf_inc, drop_inc;
  logic [DROP_CNT_WIDTH-1:0] drop_q;

  assign mseo     = Mseo_e'(in_byte[1:0]);
  assign mdo      = in_byte[7:2];
  assign in_ready = (state_q != DF_HOLD);
  assign accept   = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= DF_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and per-byte control decode.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    wr       = 1'b0;
    nf_inc   = 1'b0;
    err_set  = 1'b0;
    err_d    = DFERR_NONE;
    drop_inc = 1'b0;
    case (state_q)
      DF_IDLE: begin
        if (accept) begin
          if (mseo == MSEO_RSVD) begin
            err_set  = 1'b1;
            err_d    = DFERR_RSVD_MSEO;
            drop_inc = 1'b1;
            state_d  = DF_DROP;
          end else if (mseo != MSEO_EOM) begin
            start   = 1'b1;
            state_d = DF_COLLECT;
          end
        end
      end
      DF_COLLECT: begin
        if (accept) begin
          // Overflow is judged before MSEO; an EOM overflow byte already closes the message.
          if (chunk_cnt == 6'(MAX_CHUNKS)) begin
            err_set  = 1'b1;
            err_d    = DFERR_OVERFLOW;
            drop_inc = 1'b1;
            state_d  = (mseo == MSEO_EOM) ? DF_IDLE : DF_DROP;
          end else if (mseo == MSEO_RSVD) begin
            err_set  = 1'b1;
            err_d    = DFERR_RSVD_MSEO;
            drop_inc = 1'b1;
            state_d  = DF_DROP;
          end else begin
            wr = 1'b1;
            if (mseo != MSEO_NORMAL) nf_inc = 1'b1;
            if (mseo == MSEO_EOM)    state_d = DF_HOLD;
          end
        end
      end
      DF_HOLD: begin
        if (pkt_ready) state_d = DF_IDLE;
      end
      DF_DROP: begin
        if (accept && mseo == MSEO_EOM) state_d = DF_IDLE;
      end
      default: state_d = DF_IDLE;
    endcase
  end

  // Chunk count, field count and TCode captured alongside the packer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chunk_cnt <= '0;
      nfields_q <= '0;
      tcode_q   <= PKT_UNKNOWN;
    end else if (start) begin
      chunk_cnt <= 6'd1;
      nfields_q <= {5'd0, (mseo == MSEO_EOF)};
      tcode_q   <= to_tcode(mdo);
    end else begin
      if (wr)     chunk_cnt <= chunk_cnt + 6'd1;
      if (nf_inc) nfields_q <= nfields_q + 6'd1;
    end
  end

  // Error pulse, sticky error code and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_valid_q <= 1'b0;
      err_q       <= DFERR_NONE;
      drop_q      <= '0;
    end else begin
      err_valid_q <= err_set;
      if (err_set) err_q <= err_d;
      if (drop_inc && drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  te_mdo_packer u_packer (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .wr       (wr),
    .idx      (chunk_cnt),
    .chunk    (mdo),
    .n_chunks (chunk_cnt),
    .pkt      (pkt_out)
  );

  assign pkt_valid   = (state_q == DF_HOLD);
  assign pkt_tcode   = tcode_q;
  assign pkt_nfields = nfields_q;
  assign err_valid   = err_valid_q;
  assign err_code    = err_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_te_ntrace_deframer.sv
// Directed bench for te_ntrace_deframer.
module tb_te_ntrace_deframer;
  import te_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        pkt_valid;
  logic        pkt_ready;
  pkt_buffer_t pkt_out;
  Pkt_TCode_e  pkt_tcode;
  logic [5:0]  pkt_nfields;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] drop_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned hs_cnt = 0;
  int unsigned errp_cnt = 0;

  te_ntrace_deframer #(.DROP_CNT_WIDTH(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_byte     (in_byte),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_out     (pkt_out),
    .pkt_tcode   (pkt_tcode),
    .pkt_nfields (pkt_nfields),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset_n && pkt_valid && pkt_ready) hs_cnt++;
    if (reset_n && err_valid) errp_cnt++;
  end

  task automatic do_reset();
    in_valid = 1'b0;
    in_byte  = 8'h00;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    for (int unsigned k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin n_cmp++; n_err++; $display("FAIL send_timeout: byte %h not accepted, required accept within 100 cycles", b); end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL rst_pkt_valid: got %b exp 0", pkt_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
    n_cmp++; if (pkt_out !== '0) begin n_err++; $display("FAIL rst_pkt_out: got %h exp 0", pkt_out); end
    n_cmp++; if (pkt_tcode !== PKT_UNKNOWN || pkt_nfields !== 6'd0) begin n_err++; $display("FAIL rst_tcode_nf: got %h/%0d exp 0/0", pkt_tcode, pkt_nfields); end
    n_cmp++; if (err_valid !== 1'b0 || err_code !== 2'd0 || drop_cnt !== 16'd0) begin n_err++; $display("FAIL rst_err: got %b/%0d/%0d exp 0/0/0", err_valid, err_code, drop_cnt); end
  endtask

  task automatic test_basic();
    pkt_buffer_t exp;
    int unsigned hs0;
    exp = '0; exp.pkt_data = 256'h2A549; exp.pkt_data_len = 6'd3; exp.pkt_data_be = 32'h7;
    hs0 = hs_cnt;
    pkt_ready = 1'b1;
    repeat (5) send_byte(8'h03);
    send_byte(8'h24); send_byte(8'h55);
    @(negedge clk);
    n_cmp++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b exp 0", pkt_valid); end
    @(posedge clk); #1;
    send_byte(8'hAB);
    @(negedge clk);
    n_cmp++; if (pkt_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b exp 1", pkt_valid); end
    n_cmp++; if (pkt_out !== exp) begin n_err++; $display("FAIL basic_pkt: got %h exp %h", pkt_out, exp); end
    n_cmp++; if (pkt_tcode !== PKT_PROGTRACESYNC) begin n_err++; $display("FAIL basic_tcode: got %0d exp 9", pkt_tcode); end
    n_cmp++; if (pkt_nfields !== 6'd2) begin n_err++; $display("FAIL basic_nfields: got %0d exp 2", pkt_nfields); end
    n_cmp++; if (err_valid !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL basic_err_ready: got %b/%b exp 0/0", err_valid, in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (pkt_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL basic_release: got %b/%b exp 0/1", pkt_valid, in_ready); end
    n_cmp++; if (hs_cnt - hs0 !== 1) begin n_err++; $display("FAIL basic_hs_count: got %0d exp 1", hs_cnt - hs0); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    pkt_buffer_t exp;
    int unsigned hs0;
    exp = '0; exp.pkt_data = 256'h2A549; exp.pkt_data_len = 6'd3; exp.pkt_data_be = 32'h7;
    hs0 = hs_cnt;
    pkt_ready = 1'b0;
    send_byte(8'h24); send_byte(8'h55); send_byte(8'hAB);
    for (int unsigned c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0 || pkt_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_c%0d: ready/valid got %b/%b exp 0/1", c, in_ready, pkt_valid); end
      n_cmp++; if (pkt_out !== exp) begin n_err++; $display("FAIL bp_stable_c%0d: got %h exp %h", c, pkt_out, exp); end
    end
    pkt_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1 || pkt_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: ready/valid got %b/%b exp 1/0", in_ready, pkt_valid); end
    n_cmp++; if (hs_cnt - hs0 !== 1) begin n_err++; $display("FAIL bp_hs_count: got %0d exp 1", hs_cnt - hs0); end
    @(posedge clk); #1;
    send_byte(8'h24); send_byte(8'h55); send_byte(8'hAB);
    @(negedge clk);
    n_cmp++; if (pkt_valid !== 1'b1 || pkt_out !== exp) begin n_err++; $display("FAIL bp_next_pkt: valid %b got %h exp %h", pkt_valid, pkt_out, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_max_len();
    pkt_buffer_t exp;
    logic [255:0] d;
    d = {4'h0, {252{1'b1}}};
    d[5:0] = 6'h09;
    exp.pkt_data = d; exp.pkt_data_len = 6'd32; exp.pkt_data_be = 32'hFFFF_FFFF;
    pkt_ready = 1'b1;
    send_byte(8'h24);
    repeat (40) send_byte(8'hFC);
    send_byte(8'hFF);
    @(negedge clk);
    n_cmp++; if (pkt_valid !== 1'b1 || err_valid !== 1'b0) begin n_err++; $display("FAIL max_valid_err: got %b/%b exp 1/0", pkt_valid, err_valid); end
    n_cmp++; if (pkt_out !== exp) begin n_err++; $display("FAIL max_pkt: got %h exp %h", pkt_out, exp); end
    n_cmp++; if (pkt_nfields !== 6'd1) begin n_err++; $display("FAIL max_nfields: got %0d exp 1", pkt_nfields); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int unsigned hs0, ep0;
    do_reset();
    hs0 = hs_cnt; ep0 = errp_cnt;
    pkt_ready = 1'b1;
    send_byte(8'h24);
    repeat (41) send_byte(8'hFC);
    send_byte(8'hFC);
    @(negedge clk);
    n_cmp++; if (err_valid !== 1'b1 || err_code !== 2'd2) begin n_err++; $display("FAIL ovf_err: got %b/%0d exp 1/2", err_valid, err_code); end
    n_cmp++; if (drop_cnt !== 16'd1 || pkt_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drop: drop/valid got %0d/%b exp 1/0", drop_cnt, pkt_valid); end
    @(posedge clk); #1;
    send_byte(8'h03);
    @(negedge clk);
    n_cmp++; if (err_valid !== 1'b0 || errp_cnt - ep0 !== 1) begin n_err++; $display("FAIL ovf_pulse: valid/pulses got %b/%0d exp 0/1", err_valid, errp_cnt - ep0); end
    @(posedge clk); #1;
    send_byte(8'h24);
    repeat (41) send_byte(8'hFC);
    send_byte(8'hFF);
    @(negedge clk);
    n_cmp++; if (err_valid !== 1'b1 || err_code !== 2'd2 || drop_cnt !== 16'd2) begin n_err++; $display("FAIL ovf_eom: err/code/drop got %b/%0d/%0d exp 1/2/2", err_valid, err_code, drop_cnt); end
    @(posedge clk); #1;
    send_byte(8'h15); send_byte(8'h03);
    @(negedge clk);
    n_cmp++; if (pkt_valid !== 1'b1 || pkt_out.pkt_data !== 256'h005) begin n_err++; $display("FAIL ovf_eom_idle: valid %b data got %h exp 005", pkt_valid, pkt_out.pkt_data); end
    @(posedge clk); #1;
    n_cmp++; if (hs_cnt - hs0 !== 1) begin n_err++; $display("FAIL ovf_hs_count: got %0d exp 1", hs_cnt - hs0); end
  endtask

  task automatic test_reserved();
    pkt_buffer_t exp;
    exp = '0; exp.pkt_data = 256'h2A549; exp.pkt_data_len = 6'd3; exp.pkt_data_be = 32'h7;
    do_reset();
    pkt_ready = 1'b1;
    send_byte(8'h24); send_byte(8'h26);
    @(negedge clk);
    n_cmp++; if (err_valid !== 1'b1 || err_code !== 2'd1 || drop_cnt !== 16'd1) begin n_err++; $display("FAIL rsvd_err: err/code/drop got %b/%0d/%0d exp 1/1/1", err_valid, err_code, drop_cnt); end
    @(posedge clk); #1;
    send_byte(8'h00); send_byte(8'h03);
    @(negedge clk);
    n_cmp++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL rsvd_no_pkt: got %b exp 0", pkt_valid); end
    @(posedge clk); #1;
    send_byte(8'h24); send_byte(8'h55); send_byte(8'hAB);
    @(negedge clk);
    n_cmp++; if (pkt_valid !== 1'b1 || pkt_out !== exp) begin n_err++; $display("FAIL rsvd_next_pkt: valid %b got %h exp %h", pkt_valid, pkt_out, exp); end
    n_cmp++; if (drop_cnt !== 16'd1 || err_code !== 2'd1) begin n_err++; $display("FAIL rsvd_sticky: drop/code got %0d/%0d exp 1/1", drop_cnt, err_code); end
    @(posedge clk); #1;
    send_byte(8'h02);
    @(negedge clk);
    n_cmp++; if (err_valid !== 1'b1 || err_code !== 2'd1 || drop_cnt !== 16'd2) begin n_err++; $display("FAIL rsvd_idle: err/code/drop got %b/%0d/%0d exp 1/1/2", err_valid, err_code, drop_cnt); end
    @(posedge clk); #1;
    send_byte(8'h03);
  endtask

  task automatic test_unknown_tcode();
    pkt_buffer_t exp;
    exp = '0; exp.pkt_data = 256'h005; exp.pkt_data_len = 6'd2; exp.pkt_data_be = 32'h3;
    pkt_ready = 1'b1;
    send_byte(8'h15); send_byte(8'h03);
    @(negedge clk);
    n_cmp++; if (pkt_valid !== 1'b1 || pkt_out !== exp) begin n_err++; $display("FAIL unk_pkt: valid %b got %h exp %h", pkt_valid, pkt_out, exp); end
    n_cmp++; if (pkt_tcode !== PKT_UNKNOWN || pkt_nfields !== 6'd2) begin n_err++; $display("FAIL unk_tcode_nf: got %0d/%0d exp 0/2", pkt_tcode, pkt_nfields); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_msg();
    pkt_buffer_t exp;
    int unsigned hs0;
    exp = '0; exp.pkt_data = 256'h2A549; exp.pkt_data_len = 6'd3; exp.pkt_data_be = 32'h7;
    do_reset();
    pkt_ready = 1'b1;
    send_byte(8'h24); send_byte(8'h55);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    hs0 = hs_cnt;
    send_byte(8'h24); send_byte(8'h55); send_byte(8'hAB);
    @(negedge clk);
    n_cmp++; if (pkt_valid !== 1'b1 || pkt_out !== exp) begin n_err++; $display("FAIL rmid_pkt: valid %b got %h exp %h", pkt_valid, pkt_out, exp); end
    n_cmp++; if (pkt_tcode !== PKT_PROGTRACESYNC || pkt_nfields !== 6'd2) begin n_err++; $display("FAIL rmid_tcode_nf: got %0d/%0d exp 9/2", pkt_tcode, pkt_nfields); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL rmid_drop: got %0d exp 0", drop_cnt); end
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (hs_cnt - hs0 !== 1) begin n_err++; $display("FAIL rmid_hs_count: got %0d exp 1", hs_cnt - hs0); end
  endtask

  initial begin
    pkt_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_max_len();
    test_unknown_tcode();
    test_overflow();
    test_reserved();
    test_reset_mid_msg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
